hdmi_axi_reader: RTL
====================

Name: hdmi_axi_reader

Overview:
- AXI4 read master; serves the kick/busy/read_addr/read_num request interface driven by the HDMI scan-out address generator.
- Each kick fetches read_num data beats from DRAM, starting at read_addr, as AXI4 INCR bursts.
- Returned data goes through a one-stage registered valid/ready output into the line buffer feeding the HDMI pixel path.
- busy covers the whole transfer.

Parameters:
- DATA_WIDTH, 32, AXI data width in bits (power of two, 32..256); BYTES = DATA_WIDTH/8.
- MAX_BURST, 16, maximum beats per AXI burst (1..256).
- NUM_WIDTH, 16, width of read_num.

Ports:
- clk  in  1  single clock (video/AXI domain).
- rst_n  in  1  asynchronous, active-low reset.
- kick  in  1  one-cycle request strobe.
- read_addr  in  32  byte start address; low log2(BYTES) bits ignored (forced 0).
- read_num  in  NUM_WIDTH  beats to read.
- busy  out  1  transfer in progress.
- m_axi_araddr  out  32  burst address.
- m_axi_arlen  out  8  beats-1.
- m_axi_arsize  out  3  constant log2(BYTES).
- m_axi_arburst  out  2  constant 2'b01 (INCR).
- m_axi_arvalid  out  1  AR valid.
- m_axi_arready  in  1  AR ready.
- m_axi_rdata  in  DATA_WIDTH  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rlast  in  1  last beat of burst.
- m_axi_rvalid  in  1  R valid.
- m_axi_rready  out  1  R ready.
- dout  out  DATA_WIDTH  output data.
- dout_valid  out  1  output valid.
- dout_ready  in  1  downstream ready.
- err  out  1  sticky error flag.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. busy, m_axi_arvalid, m_axi_rready, dout_valid, err all 0. araddr, arlen, dout all 0. Any in-flight AXI transaction is abandoned; the interconnect shares the same reset.
- States: IDLE, ADDR, DATA.
- IDLE:
  - kick with read_num!=0: latch addr=read_addr with low bits cleared, and rem=read_num. Go to ADDR; busy=1 from the next cycle.
  - kick with read_num==0: ignored; busy stays 0.
  - kick outside IDLE: ignored.
- ADDR:
  - len = min(rem, MAX_BURST, (4096-addr[11:0])/BYTES). Bursts never cross a 4 KB boundary.
  - araddr=addr and arlen=len-1 are registered when ADDR is entered.
  - arvalid=1 and held, with araddr/arlen stable, until arready. On the handshake: arvalid=0, go to DATA. Only one burst is outstanding at a time.
- DATA:
  - m_axi_rready = !dout_valid || dout_ready.
  - Each R handshake loads the beat into dout and sets dout_valid; beat counter++.
  - dout_valid clears on dout_ready when no new beat arrives the same cycle. Simultaneous consume and load keeps dout_valid=1 with the new data.
  - Throughput: 1 beat/cycle while dout_ready stays high.
  - The beat counter is authoritative. At beat==len: rem-=len; addr+=len*BYTES, 32-bit wrap allowed. If rem!=0 go to ADDR, else go to IDLE and busy=0 on the next cycle.
  - busy falls after the last R handshake, not after the last dout handshake; the output register may still hold the final beat.
- Error:
  - rresp!=2'b00 on any beat, or rlast not coinciding with beat==len, sets err=1.
  - err is sticky until reset; the data is still forwarded and the transfer completes.
- Ordering: dout order equals address order; no beat is dropped or duplicated under arbitrary dout_ready or rvalid stalls.

Test Plan:
- kick, addr 0x0000_1000, num 40 -> AR bursts (0x1000, arlen 15), (0x1040, arlen 15), (0x1080, arlen 7). 40 dout beats equal to the memory model data in order. busy high from the cycle after kick until the cycle after the 40th R handshake.
- kick, addr 0x0000_1FF8, num 8 -> bursts (0x1FF8, arlen 1) then (0x2000, arlen 5). No burst crosses 4 KB.
- dout_ready low for 20 cycles during the second burst -> rready low after one buffered beat. No loss or duplication; all 40 beats arrive in order.
- kick with num 0 -> no arvalid, busy stays 0. Second kick while busy=1 -> ignored; exactly one transfer's beats are produced.
- rresp=2'b10 on beat 3 -> err=1 from the next cycle and stays 1. The transfer still completes with 40 beats. Early rlast also sets err.
- rst_n low mid-burst -> all outputs 0 immediately, no clock needed. After release, kick addr 0x2000 num 4 -> single burst (0x2000, arlen 3), 4 beats.

Source files
------------

// File: rtl/hdmi_axi_reader.sv
// ---------------------------------------------------------------------------
// hdmi_axi_reader
//
// AXI4 read master serving the HDMI scan-out address generator. A kick
// with a non-zero read_num fetches read_num beats starting at read_addr,
// split into INCR bursts that never exceed MAX_BURST beats and never cross
// a 4 KB page. Only one burst is outstanding at a time. Returned beats pass
// through a single registered valid/ready stage towards the line buffer.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   kick                   one-cycle request strobe (honoured only when idle)
//   read_addr, read_num    byte start address (beat aligned), beat count
//   busy                   high from the cycle after kick until the cycle
//                          after the last R handshake
//   m_axi_ar*              AXI4 read address channel (master side)
//   m_axi_r*               AXI4 read data channel (master side)
//   dout, dout_valid,
//   dout_ready             registered output stream
//   err                    sticky: bad rresp or misplaced rlast seen
// ---------------------------------------------------------------------------
module hdmi_axi_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int NUM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  kick,
  input  logic [31:0]           read_addr,
  input  logic [NUM_WIDTH-1:0]  read_num,
  output logic                  busy,
  output logic [31:0]           m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [31:0]           r_addr;
  logic [NUM_WIDTH-1:0]  r_rem;
  logic [8:0]            r_len;
  logic [8:0]            r_beat;
  logic [7:0]            r_arlen;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_doutValid;
  logic                  r_err;

  logic                  w_loadBurst;
  logic                  w_rFire;
  logic [8:0]            w_beatNext;
  logic                  w_lastBeat;
  logic [31:0]           w_addrAdv;
  logic [NUM_WIDTH-1:0]  w_remAdv;
  logic [31:0]           w_seedAddr;
  logic [NUM_WIDTH-1:0]  w_seedRem;
  logic [31:0]           w_pageBeats;
  logic [31:0]           w_remWide;
  logic [31:0]           w_minLen;
  logic [8:0]            w_seedLen;

  assign w_rFire    = m_axi_rvalid && m_axi_rready;
  assign w_beatNext = r_beat + 9'd1;
  assign w_lastBeat = (w_beatNext == r_len);

  // Position of the next burst once the current one has fully returned.
  assign w_addrAdv = r_addr + (32'(r_len) << LSB);
  assign w_remAdv  = r_rem - NUM_WIDTH'(r_len);

  // A new burst is seeded either from the request (first burst) or from
  // the advanced position (follow-on bursts).
  assign w_seedAddr = (r_state == IDLE) ? (read_addr & ~32'(BYTES - 1)) : w_addrAdv;
  assign w_seedRem  = (r_state == IDLE) ? read_num : w_remAdv;

  // Beats left before the 4 KB page boundary; the address is beat aligned
  // so the division is exact.
  assign w_pageBeats = (32'd4096 - {20'd0, w_seedAddr[11:0]}) >> LSB;
  assign w_remWide   = 32'(w_seedRem);

  always_comb begin
    w_minLen = w_remWide;
    if (w_minLen > 32'(MAX_BURST)) begin
      w_minLen = 32'(MAX_BURST);
    end
    if (w_minLen > w_pageBeats) begin
      w_minLen = w_pageBeats;
    end
  end

  assign w_seedLen = w_minLen[8:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic; w_loadBurst marks every entry into ADDR.
  always_comb begin
    w_stateNext = r_state;
    w_loadBurst = 1'b0;
    case (r_state)
      IDLE: begin
        if (kick && (read_num != '0)) begin
          w_stateNext = ADDR;
          w_loadBurst = 1'b1;
        end
      end
      ADDR: begin
        if (m_axi_arready) begin
          w_stateNext = DATA;
        end
      end
      DATA: begin
        if (w_rFire && w_lastBeat) begin
          if (w_remAdv != '0) begin
            w_stateNext = ADDR;
            w_loadBurst = 1'b1;
          end else begin
            w_stateNext = IDLE;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Burst bookkeeping, output register and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_rem       <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_arlen     <= '0;
      r_dout      <= '0;
      r_doutValid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_loadBurst) begin
        r_addr  <= w_seedAddr;
        r_rem   <= w_seedRem;
        r_len   <= w_seedLen;
        r_beat  <= '0;
        r_arlen <= 8'(w_seedLen - 9'd1);
      end else if (w_rFire) begin
        r_beat <= w_beatNext;
      end

      // A load wins over a consume so back-to-back beats stream at full rate.
      if (w_rFire) begin
        r_dout      <= m_axi_rdata;
        r_doutValid <= 1'b1;
      end else if (dout_ready) begin
        r_doutValid <= 1'b0;
      end

      // rlast must land exactly on the counted last beat.
      if (w_rFire && ((m_axi_rresp != 2'b00) || (m_axi_rlast != w_lastBeat))) begin
        r_err <= 1'b1;
      end
    end
  end

  assign busy          = (r_state != IDLE);
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = r_arlen;
  assign m_axi_arsize  = 3'(LSB);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = (r_state == ADDR);
  assign m_axi_rready  = (r_state == DATA) && (!r_doutValid || dout_ready);
  assign dout          = r_dout;
  assign dout_valid    = r_doutValid;
  assign err           = r_err;

endmodule
